// File: rtl/complex_operand_feeder_pkg.sv
// complex_operand_feeder_pkg: shared widths, slot length, phase type and operand-set layout
package complex_operand_feeder_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int SLOT = 4;
  typedef logic [1:0] phase_t;
  typedef struct packed {
    logic [WIDTH_DEF-1:0] a1;
    logic [WIDTH_DEF-1:0] b1;
    logic [WIDTH_DEF-1:0] a2;
    logic [WIDTH_DEF-1:0] b2;
  } opset_t;
endpackage

// File: rtl/complex_operand_feeder_if.sv
// complex_operand_feeder_if: producer handshake, issued operands and status of the operand feeder
interface complex_operand_feeder_if #(
  parameter int WIDTH = complex_operand_feeder_pkg::WIDTH_DEF,
  parameter int DEPTH = 4
);
  import complex_operand_feeder_pkg::*;
  logic flush, in_valid, in_ready, out_valid, out_start;
  logic [WIDTH-1:0] in_a1, in_b1, in_a2, in_b2;
  logic [WIDTH-1:0] out_a1, out_b1, out_a2, out_b2;
  phase_t phase;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output flush, in_valid, in_a1, in_b1, in_a2, in_b2,
    input in_ready, out_a1, out_b1, out_a2, out_b2, out_valid, out_start, phase, count
  );
  modport slave (
    input flush, in_valid, in_a1, in_b1, in_a2, in_b2,
    output in_ready, out_a1, out_b1, out_a2, out_b2, out_valid, out_start, phase, count
  );
endinterface

// File: rtl/complex_operand_feeder_cplx_sync_fifo.sv
// cplx_sync_fifo: DEPTH x W synchronous FIFO with explicit occupancy register and flush
module cplx_sync_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    full = count_q == CW'(DEPTH);
    empty = count_q == '0;
    do_push = push && !full && !flush;
    do_pop = pop && !empty && !flush;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(do_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(do_pop);
    count_d = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/complex_operand_feeder.sv
// complex_operand_feeder: buffers operand sets and issues one per multiplier slot, phase-aligned
module complex_operand_feeder
  import complex_operand_feeder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  complex_operand_feeder_if.slave bus
);
  localparam int SW = 4 * WIDTH;
  phase_t phase_q, phase_d;
  logic [SW-1:0] set_q, set_d, head;
  logic out_valid_q, out_valid_d, out_start_q, out_start_d;
  logic boundary, full, empty;
  cplx_sync_fifo #(.W(SW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.flush),
    .push  (bus.in_valid),
    .pop   (boundary),
    .wdata ({bus.in_a1, bus.in_b1, bus.in_a2, bus.in_b2}),
    .rdata (head),
    .count (bus.count),
    .full  (full),
    .empty (empty)
  );
  // Phase keeps running through flush so the multiplier schedule never slips
  always_comb begin
    boundary = phase_q == phase_t'(SLOT - 1);
    phase_d = phase_q + 2'd1;
    set_d = bus.flush ? '0 : boundary ? (empty ? '0 : head) : set_q;
    out_valid_d = bus.flush ? 1'b0 : boundary ? !empty : out_valid_q;
    out_start_d = !bus.flush && boundary && !empty;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      set_q <= '0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      set_q <= set_d;
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
    end
  end
  assign bus.in_ready = !full;
  assign {bus.out_a1, bus.out_b1, bus.out_a2, bus.out_b2} = set_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_start = out_start_q;
  assign bus.phase = phase_q;
endmodule

// File: doc/complex_operand_feeder.md
# complex_operand_feeder

Upstream operand stage for the time-shared complex multiplier. Accepts complex operand sets (a1, b1, a2, b2) on a valid/ready handshake, buffers them in a small FIFO, and issues one set per 4-cycle multiplier slot. Each issued set is held stable for the whole slot, aligned to the multiplier's internal phase. This lets a bursty producer drive a datapath that can only start one complex product every SLOT cycles.

## Interface
- WIDTH, 8, bit width of each real/imag operand component
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2
- SLOT, 4, cycles per multiplier slot; fixed at 4 to match the single-multiplier schedule
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous clear of FIFO and issued operands
- in_valid  in  1  producer holds an operand set
- in_ready  out  1  FIFO can accept a set this cycle
- in_a1, in_b1, in_a2, in_b2  in  WIDTH each  operand set: re/im of operand 1, re/im of operand 2
- out_a1, out_b1, out_a2, out_b2  out  WIDTH each  issued operand set, registered
- out_valid  out  1  issued operands are valid for the current slot
- out_start  out  1  one-cycle pulse in the first cycle of a slot carrying a newly issued set
- phase  out  2  current slot phase, 0..SLOT-1, for alignment with the multiplier
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Phase counter:
  - Free-running 0,1,2,3,0,… from reset.
  - Not affected by flush, so alignment with the downstream multiplier is preserved.
- Push:
  - A set is written on any rising edge where in_valid && in_ready.
  - in_ready = (count != DEPTH). It is combinational from count and does not depend on in_valid.
  - There is no push-through-pop when full: in_ready is low while full, even on a pop edge.
- Pop, on the edge where phase == SLOT-1 (the slot boundary):
  - FIFO non-empty: the head moves into out_* and out_valid becomes 1.
  - FIFO empty: out_* become 0 and out_valid becomes 0 (bubble slot).
- Bypass: the pop samples FIFO contents from before the edge. A set pushed on the boundary edge itself is issued at the next boundary, with no bypass.
- Simultaneous push and pop: count is unchanged, and both the write and read pointers advance.
- Pointers: DEPTH-modulo counters that wrap naturally. count is kept as an explicit register, not derived from the pointers.
- flush = 1 takes priority over push and pop on that edge:
  - count, pointers, out_*, out_valid and out_start all go to 0.
  - A push presented in the same cycle is dropped.
- Order: strict FIFO; no set is reordered, duplicated or lost except by flush or reset.

## Timing
- Reset values (while rst_n is low): phase = 0, count = 0, out_* = 0, out_valid = 0, out_start = 0. in_ready = 1, but pushes are ignored during reset.
- First boundary: the 4th rising edge after rst_n deasserts.
- out_start:
  - Registered; high exactly in the phase-0 cycle following a boundary that popped a set.
  - Never high in the first cycle after reset.
- Issued operands: out_* and out_valid change only on boundary edges (or on flush/reset) and stay stable for SLOT cycles.
- Latency, push to issue:
  - Minimum 1 cycle: push on the phase-2 edge, issue on the phase-3 edge.
  - Maximum SLOT cycles when the FIFO was empty, plus SLOT per set ahead in the queue.
- Throughput: at most one set per SLOT cycles. With a sustained producer, in_ready settles to 1 in every SLOT cycles once full.
- Reset mid-slot: all state clears immediately and asynchronously. The phase restarts at 0 after release, and the downstream multiplier must be reset together with this block.

## Structure
- Shared package: WIDTH default, SLOT constant, phase type (2-bit), and a packed operand-set struct {a1, b1, a2, b2}.
- One sub-module: cplx_sync_fifo, a generic DEPTH x 4*WIDTH synchronous FIFO with push/pop/flush/count.
- The top level holds the phase counter, issue registers and out_start.

## Test plan
- Reset check: drive rst_n low mid-run:
  - During reset: all outputs 0, in_ready = 1, phase = 0.
  - After release: phase steps 0,1,2,3.
  - out_valid stays 0 with no input.
- Single set: push (a1 = 3, b1 = 4, a2 = 5, b2 = 6) at phase 1.
  - Set appears on out_* at the next phase 0, with out_start high for 1 cycle.
  - out_valid stays high for 4 cycles, then the bubble drives out_* = 0 and out_valid = 0.
- Boundary push: push (7, 8, 9, 10) on the phase-3 edge with the FIFO empty.
  - Not issued at that boundary; issued 4 cycles later.
- Burst/backpressure: hold in_valid high with sets whose a1 = 1..8.
  - in_ready drops when count = 4.
  - Sets 1..8 are issued in order, one per slot, each held 4 cycles, none lost or duplicated.
- Flush: load 3 sets, assert flush at phase 2 while pushing a 4th set.
  - count = 0, out_valid = 0 and out_* = 0 on the next edge.
  - The pushed set is dropped, and phase continues to 3 then 0 without out_start.
- Wrap-around: push and pop 3*DEPTH sets with mixed idle gaps.
  - Issued sequence matches a scoreboard model exactly.
  - count is never greater than DEPTH.
